// File: rtl/ps2_mouse_cursor_rx.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ps2_mouse_cursor_rx : receive-only PS/2 mouse deframer, 3-byte packet parser
// and clamped cursor accumulator.                        Revision 1.0
// ----------------------------------------------------------------------------
module ps2_mouse_cursor_rx #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 200000,
    parameter int X_MAX      = 319,
    parameter int Y_MAX      = 239,
    parameter int X_INIT     = 160,
    parameter int Y_INIT     = 120
) (
    input  logic       clk_100MHz,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic       btn_left,
    output logic       btn_right,
    output logic       btn_middle,
    output logic       pkt_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    logic [1:0]  clk_sync_q, clk_sync_d;
    logic [1:0]  dat_sync_q, dat_sync_d;
    logic [FW-1:0] flt_cnt_q, flt_cnt_d;
    logic        fclk_q, fclk_d;
    logic        fall_q, fall_d;
    logic        smp_q, smp_d;
    logic [1:0]  state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  data_q, data_d;
    logic        par_q, par_d;
    logic        stop_q, stop_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [1:0]  idx_q, idx_d;
    // hdr = {y_ovf, x_ovf, y_sign, x_sign, mid, right, left}
    logic [6:0]  hdr_q, hdr_d;
    logic [7:0]  b1_q, b1_d;
    logic [7:0]  b2_q, b2_d;
    logic        upd_q, upd_d;
    logic [8:0]  xm_q, xm_d;
    logic [8:0]  ym_q, ym_d;
    logic [2:0]  btn_q, btn_d;
    logic        pkt_valid_q, pkt_valid_d;
    logic        frame_err_q, frame_err_d;

    logic signed [10:0] dx, dy, nx, ny;

    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk};
        dat_sync_d  = {dat_sync_q[0], ps2_data};
        flt_cnt_d   = '0;
        fclk_d      = fclk_q;
        fall_d      = 1'b0;
        smp_d       = smp_q;
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        data_d      = data_q;
        par_d       = par_q;
        stop_d      = stop_q;
        to_cnt_d    = to_cnt_q;
        idx_d       = idx_q;
        hdr_d       = hdr_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        upd_d       = 1'b0;
        xm_d        = xm_q;
        ym_d        = ym_q;
        btn_d       = btn_q;
        pkt_valid_d = 1'b0;
        frame_err_d = 1'b0;

        // Glitch filter: the filtered clock follows only a stable input.
        if (clk_sync_q[1] != fclk_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
                fclk_d = clk_sync_q[1];
                fall_d = fclk_q;
                smp_d  = dat_sync_q[1];
            end else begin
                flt_cnt_d = flt_cnt_q + FW'(1);
            end
        end

        if (fall_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TW'(TIMEOUT)) begin
            to_cnt_d = to_cnt_q + TW'(1);
        end

        case (state_q)
            ST_IDLE: begin
                if (fall_q && !smp_q) begin
                    state_d   = ST_SHIFT;
                    bit_cnt_d = 4'd0;
                end
            end
            ST_SHIFT: begin
                if (fall_q) begin
                    if (bit_cnt_q < 4'd8) begin
                        data_d = {smp_q, data_q[7:1]};
                    end else if (bit_cnt_q == 4'd8) begin
                        par_d = smp_q;
                    end else begin
                        stop_d  = smp_q;
                        state_d = ST_CHECK;
                    end
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end
            ST_CHECK: begin
                state_d   = ST_IDLE;
                bit_cnt_d = 4'd0;
                if ((^{data_q, par_q}) && stop_q) begin
                    case (idx_q)
                        2'd0: begin
                            // Header must carry the always-one bit 3, else resync.
                            if (data_q[3]) begin
                                hdr_d = {data_q[7:4], data_q[2:0]};
                                idx_d = 2'd1;
                            end
                        end
                        2'd1: begin
                            b1_d  = data_q;
                            idx_d = 2'd2;
                        end
                        default: begin
                            b2_d  = data_q;
                            upd_d = 1'b1;
                        end
                    endcase
                end else begin
                    frame_err_d = 1'b1;
                    idx_d       = 2'd0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_CHECK && !upd_q && to_cnt_q == TW'(TIMEOUT) &&
            (state_q == ST_SHIFT || idx_q != 2'd0)) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            bit_cnt_d   = 4'd0;
            idx_d       = 2'd0;
        end

        dx = {{2{hdr_q[3]}}, hdr_q[3], b1_q};
        dy = {{2{hdr_q[4]}}, hdr_q[4], b2_q};
        nx = $signed({2'b00, xm_q}) + dx;
        ny = $signed({2'b00, ym_q}) - dy;

        if (upd_q) begin
            btn_d       = hdr_q[2:0];
            pkt_valid_d = 1'b1;
            idx_d       = 2'd0;
            if (!hdr_q[5]) begin
                if (nx < 0)            xm_d = 9'd0;
                else if (nx > X_MAX_S) xm_d = 9'(X_MAX);
                else                   xm_d = nx[8:0];
            end
            if (!hdr_q[6]) begin
                if (ny < 0)            ym_d = 9'd0;
                else if (ny > Y_MAX_S) ym_d = 9'(Y_MAX);
                else                   ym_d = ny[8:0];
            end
        end
    end

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            clk_sync_q  <= 2'b11;
            dat_sync_q  <= 2'b11;
            flt_cnt_q   <= '0;
            fclk_q      <= 1'b1;
            fall_q      <= 1'b0;
            smp_q       <= 1'b1;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= 4'd0;
            data_q      <= 8'd0;
            par_q       <= 1'b0;
            stop_q      <= 1'b0;
            to_cnt_q    <= '0;
            idx_q       <= 2'd0;
            hdr_q       <= 7'd0;
            b1_q        <= 8'd0;
            b2_q        <= 8'd0;
            upd_q       <= 1'b0;
            xm_q        <= 9'(X_INIT);
            ym_q        <= 9'(Y_INIT);
            btn_q       <= 3'd0;
            pkt_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            clk_sync_q  <= clk_sync_d;
            dat_sync_q  <= dat_sync_d;
            flt_cnt_q   <= flt_cnt_d;
            fclk_q      <= fclk_d;
            fall_q      <= fall_d;
            smp_q       <= smp_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            data_q      <= data_d;
            par_q       <= par_d;
            stop_q      <= stop_d;
            to_cnt_q    <= to_cnt_d;
            idx_q       <= idx_d;
            hdr_q       <= hdr_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            upd_q       <= upd_d;
            xm_q        <= xm_d;
            ym_q        <= ym_d;
            btn_q       <= btn_d;
            pkt_valid_q <= pkt_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign xm         = xm_q;
    assign ym         = ym_q;
    assign btn_left   = btn_q[0];
    assign btn_right  = btn_q[1];
    assign btn_middle = btn_q[2];
    assign pkt_valid  = pkt_valid_q;
    assign frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: doc/ps2_mouse_cursor_rx.md
Name: ps2_mouse_cursor_rx

Overview:
- Receive-only PS/2 mouse front end. Produces the cursor coordinates (xm, ym) and button states that the VGA painter consumes.
- Deframes 11-bit PS/2 device-to-host frames and assembles standard 3-byte movement packets.
- Accumulates signed deltas into clamped screen coordinates.
- Mouse stream-mode enable (0xF4) is issued by a separate host-transmit block. This block never drives ps2_clk or ps2_data.

Parameters:
- FILTER_LEN, 8: consecutive identical ps2_clk samples required before the filtered clock changes.
- TIMEOUT, 200000: idle cycles (2 ms at 100 MHz) mid-frame or mid-packet before state is discarded.
- X_MAX, 319: maximum xm value.
- Y_MAX, 239: maximum ym value.
- X_INIT, 160: xm value after reset.
- Y_INIT, 120: ym value after reset.

Ports:
- clk_100MHz  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ps2_clk  in  1  raw PS/2 clock, asynchronous to clk_100MHz.
- ps2_data  in  1  raw PS/2 data, asynchronous to clk_100MHz.
- xm  out  9  cursor X, range 0..X_MAX.
- ym  out  9  cursor Y, range 0..Y_MAX; 0 is the top of the screen.
- btn_left  out  1  left button state from the last valid packet.
- btn_right  out  1  right button state from the last valid packet.
- btn_middle  out  1  middle button state from the last valid packet.
- pkt_valid  out  1  one-cycle pulse when a packet has been applied.
- frame_err  out  1  one-cycle pulse on start, parity or stop error, or on timeout.

Behaviour:
- Interface: one clock (clk_100MHz). Reset is asynchronous, active-high (reset). Reset asserted at any time clears all state immediately, including mid-frame and mid-packet.
- Reset values: xm=X_INIT, ym=Y_INIT, btn_*=0, pkt_valid=0, frame_err=0. Filtered clock=1, bit counter=0, byte index=0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - Filtered clock changes only after FILTER_LEN consecutive equal synced samples.
  - The bit sample point is the filtered-clock falling edge, using synced ps2_data.
- Frame FSM states: IDLE, SHIFT, CHECK.
  - IDLE -> SHIFT on a falling edge with data=0 (start bit). A falling edge with data=1 in IDLE is ignored.
  - SHIFT captures 8 data bits LSB-first, then parity, then stop.
  - SHIFT -> CHECK after the stop bit is sampled.
  - CHECK is valid when the 8 data bits plus the parity bit have an odd total count of 1s and stop=1. A valid frame hands the byte to the packet stage. An invalid frame pulses frame_err and resets the packet stage to byte index 0.
  - CHECK -> IDLE after one cycle.
- Timeout counter:
  - Cleared on every filtered falling edge.
  - When it reaches TIMEOUT while in SHIFT, or while the packet byte index is not 0: pulse frame_err, return to IDLE, set byte index to 0.
  - Counter saturates; it does not wrap.
- Packet stage, byte index 0..2:
  - Byte 0 is accepted only if bit3=1. Otherwise it is silently dropped for resync and the index stays 0.
  - Byte 0 fields: bit0=L, bit1=R, bit2=M, bit4=X sign, bit5=Y sign, bit6=X overflow, bit7=Y overflow.
  - Byte 1 = dx[7:0]. Byte 2 = dy[7:0].
  - dx and dy are 9-bit two's complement {sign, byte}, range -256..+255.
- Update (cycle after byte 2 is accepted):
  - btn_* loaded from byte 0.
  - nx = xm + dx and ny = ym - dy, computed in 11-bit signed (mouse +Y is up).
  - Result clamped to 0..X_MAX and 0..Y_MAX. Below 0 gives 0; above the maximum gives the maximum.
  - If the X overflow bit is set, xm is unchanged. If the Y overflow bit is set, ym is unchanged. Buttons still update in either case.
  - pkt_valid pulses high for one cycle in that same cycle; xm, ym and btn_* show the new values from that cycle on.
  - Byte index returns to 0.
- Latency: pkt_valid rises exactly 2 clk_100MHz cycles after the CHECK cycle of byte 2.
- Simultaneous events: if a timeout and a valid-frame CHECK occur in the same cycle, the CHECK wins and the timeout is ignored. frame_err and pkt_valid are never high in the same cycle.
- Outputs are registered, with no combinational path from the inputs.

Test Plan:
- Reset then idle lines (ps2_clk=1, ps2_data=1) for 1 ms -> xm=160, ym=120, btn_*=0, no pulses.
- Packet 0x09,0x0A,0x05 (L pressed, dx=+10, dy=+5) -> one pkt_valid; xm=170, ym=115, btn_left=1.
- Packet 0x38,0x00,0x00 (dx=-256, dy=-256) from reset -> xm=0, ym=239 (clamped), btn_*=0.
- Byte 0x0A with a corrupted parity bit -> frame_err pulse, no pkt_valid. A following clean 0x08,0x01,0x01 applies dx=+1, dy=+1 (xm=161, ym=119).
- Byte 0x08, 0x05, then 3 ms silence, then 0x08,0x02,0x00 -> frame_err pulse after the timeout; final xm=162, ym=120.
- Glitch: a 3-cycle low pulse on ps2_clk -> filtered out; no bit shifted, no frame_err. Assert reset mid-frame -> outputs return to reset values immediately.
